// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   ID-stage branch/jump resolver. It latches the fetch-stage BTB prediction next
//   to the instruction entering ID. It then resolves the real outcome within the
//   same cycle and sends redirect, flush and BTB-training commands back to fetch.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   pc_write              pipeline advance (0 = stall, ID registers hold)
//   if_pc, if_find_in_btb, if_btb_taken, if_pred_target
//                         fetch-side PC and BTB lookup result, captured into ID
//   id_is_branch, id_branch_ne, id_is_jump, id_rs_data, id_rt_data,
//   id_imm, id_jmp_index  decoded ID instruction and forwarded operands
//   pc_src                [0] take branch target, [1] take jump address
//   write_entry           BTB command: 000 none, 001 allocate, 010 train taken,
//                         011 fix target, 100 train not-taken
//   pc_plus4_plus_off     branch target of the ID instruction
//   jmp_addr              jump target of the ID instruction
//   pc_stage2             PC of the ID instruction
//   flush                 squash the IF/ID instruction on the next advancing edge
//   mispredict            the ID branch was mispredicted
//
// Optional build macro BRU_PERF_CNT_EN adds saturating performance counters
// br_count, mp_count and jmp_count (CNT_W bits each).

module branch_resolve_unit #(
  parameter int AW    = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pc_write,
  input  logic [AW-1:0] if_pc,
  input  logic          if_find_in_btb,
  input  logic          if_btb_taken,
  input  logic [AW-1:0] if_pred_target,
  input  logic          id_is_branch,
  input  logic          id_branch_ne,
  input  logic          id_is_jump,
  input  logic [AW-1:0] id_rs_data,
  input  logic [AW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic [25:0]   id_jmp_index,
  output logic [1:0]    pc_src,
  output logic [2:0]    write_entry,
  output logic [AW-1:0] pc_plus4_plus_off,
  output logic [AW-1:0] jmp_addr,
  output logic [AW-1:0] pc_stage2,
  output logic          flush,
  output logic          mispredict
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count,
  output logic [CNT_W-1:0] jmp_count
`endif
);

  // BTB command encodings as seen by fetch.
  localparam logic [2:0] WE_NONE     = 3'b000;
  localparam logic [2:0] WE_ALLOC    = 3'b001;
  localparam logic [2:0] WE_TRAIN_T  = 3'b010;
  localparam logic [2:0] WE_FIX_TGT  = 3'b011;
  localparam logic [2:0] WE_TRAIN_NT = 3'b100;

  // Resolution classes of the ID instruction.
  typedef enum logic [2:0] {
    RES_NONE,      // bubble, non-control instruction or correctly predicted branch
    RES_JUMP,      // unconditional jump, always redirected from ID
    RES_ALLOC,     // taken branch that missed in the BTB
    RES_FIX_TGT,   // taken as predicted, but the stored target is stale
    RES_TRAIN_NT,  // predicted taken, actually not taken
    RES_TRAIN_T    // predicted not-taken, actually taken
  } res_e;

  // ---------------------------------------------------------------------------
  // ID-side registers
  // ---------------------------------------------------------------------------
  logic [AW-1:0] id_pc_q,       id_pc_d;
  logic          id_found_q,    id_found_d;
  logic          id_taken_q,    id_taken_d;
  logic [AW-1:0] id_pred_tgt_q, id_pred_tgt_d;
  logic          id_valid_q,    id_valid_d;

  always_comb begin
    id_pc_d       = id_pc_q;
    id_found_d    = id_found_q;
    id_taken_d    = id_taken_q;
    id_pred_tgt_d = id_pred_tgt_q;
    id_valid_d    = id_valid_q;
    if (pc_write) begin
      id_pc_d       = if_pc;
      id_found_d    = if_find_in_btb;
      id_taken_d    = if_btb_taken;
      id_pred_tgt_d = if_pred_target;
      // The instruction squashed by a redirect enters ID as a bubble.
      id_valid_d    = ~flush;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_pc_q       <= '0;
      id_found_q    <= 1'b0;
      id_taken_q    <= 1'b0;
      id_pred_tgt_q <= '0;
      id_valid_q    <= 1'b0;
    end else begin
      id_pc_q       <= id_pc_d;
      id_found_q    <= id_found_d;
      id_taken_q    <= id_taken_d;
      id_pred_tgt_q <= id_pred_tgt_d;
      id_valid_q    <= id_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Target arithmetic (modulo 2^AW)
  // ---------------------------------------------------------------------------
  logic [AW-1:0] pc_plus4;
  logic [AW-1:0] br_off;

  assign pc_plus4          = id_pc_q + AW'(4);
  // Word offset: sign-extend the 16-bit immediate and scale it to bytes.
  assign br_off            = {{(AW-18){id_imm[15]}}, id_imm, 2'b00};
  assign pc_plus4_plus_off = pc_plus4 + br_off;
  // The jump keeps the region bits of the sequential PC above the 28-bit index span.
  assign jmp_addr          = {pc_plus4[AW-1:28], id_jmp_index, 2'b00};
  assign pc_stage2         = id_pc_q;

  // ---------------------------------------------------------------------------
  // Outcome classification
  // ---------------------------------------------------------------------------
  logic actual_taken;
  logic tgt_match;
  logic is_jump_v;
  logic is_branch_v;
  res_e res;

  assign actual_taken = (id_rs_data == id_rt_data) ^ id_branch_ne;
  assign tgt_match    = (id_pred_tgt_q == pc_plus4_plus_off);
  // If branch and jump are both decoded, the jump takes priority.
  assign is_jump_v    = id_valid_q & id_is_jump;
  assign is_branch_v  = id_valid_q & id_is_branch & ~id_is_jump;

  always_comb begin
    res = RES_NONE;
    if (is_jump_v) begin
      res = RES_JUMP;
    end else if (is_branch_v) begin
      if (!id_found_q) begin
        if (actual_taken) res = RES_ALLOC;
      end else if (id_taken_q) begin
        if (!actual_taken)   res = RES_TRAIN_NT;
        else if (!tgt_match) res = RES_FIX_TGT;
      end else begin
        if (actual_taken) res = RES_TRAIN_T;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_src      = 2'b00;
    write_entry = WE_NONE;
    flush       = 1'b0;
    mispredict  = 1'b0;
    unique case (res)
      RES_JUMP: begin
        pc_src = 2'b10;
        flush  = 1'b1;
      end
      RES_ALLOC: begin
        pc_src      = 2'b01;
        write_entry = WE_ALLOC;
        flush       = 1'b1;
        mispredict  = 1'b1;
      end
      RES_FIX_TGT: begin
        pc_src      = 2'b01;
        write_entry = WE_FIX_TGT;
        flush       = 1'b1;
        mispredict  = 1'b1;
      end
      RES_TRAIN_NT: begin
        // Fetch rebuilds the fall-through PC from pc_stage2, so pc_src stays 00.
        write_entry = WE_TRAIN_NT;
        flush       = 1'b1;
        mispredict  = 1'b1;
      end
      RES_TRAIN_T: begin
        pc_src      = 2'b01;
        write_entry = WE_TRAIN_T;
        flush       = 1'b1;
        mispredict  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BRU_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters; they count only on advancing edges, so
  // stalled cycles never count an event twice.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] br_cnt_q,  br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q,  mp_cnt_d;
  logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mp_cnt_d  = mp_cnt_q;
    jmp_cnt_d = jmp_cnt_q;
    if (pc_write) begin
      if (is_branch_v && !(&br_cnt_q))  br_cnt_d  = br_cnt_q + CNT_W'(1);
      if (mispredict  && !(&mp_cnt_q))  mp_cnt_d  = mp_cnt_q + CNT_W'(1);
      if (is_jump_v   && !(&jmp_cnt_q)) jmp_cnt_d = jmp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q  <= '0;
      mp_cnt_q  <= '0;
      jmp_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mp_cnt_q  <= mp_cnt_d;
      jmp_cnt_q <= jmp_cnt_d;
    end
  end

  assign br_count  = br_cnt_q;
  assign mp_count  = mp_cnt_q;
  assign jmp_count = jmp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int AW    = 32;
  localparam int CNT_W = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pc_write;
  logic [AW-1:0] if_pc;
  logic          if_find_in_btb;
  logic          if_btb_taken;
  logic [AW-1:0] if_pred_target;
  logic          id_is_branch;
  logic          id_branch_ne;
  logic          id_is_jump;
  logic [AW-1:0] id_rs_data;
  logic [AW-1:0] id_rt_data;
  logic [15:0]   id_imm;
  logic [25:0]   id_jmp_index;
  logic [1:0]    pc_src;
  logic [2:0]    write_entry;
  logic [AW-1:0] pc_plus4_plus_off;
  logic [AW-1:0] jmp_addr;
  logic [AW-1:0] pc_stage2;
  logic          flush;
  logic          mispredict;
`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_count, mp_count, jmp_count;
`endif

  branch_resolve_unit #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write),
    .if_pc(if_pc), .if_find_in_btb(if_find_in_btb), .if_btb_taken(if_btb_taken),
    .if_pred_target(if_pred_target),
    .id_is_branch(id_is_branch), .id_branch_ne(id_branch_ne), .id_is_jump(id_is_jump),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_jmp_index(id_jmp_index),
    .pc_src(pc_src), .write_entry(write_entry), .pc_plus4_plus_off(pc_plus4_plus_off),
    .jmp_addr(jmp_addr), .pc_stage2(pc_stage2), .flush(flush), .mispredict(mispredict)
`ifdef BRU_PERF_CNT_EN
    , .br_count(br_count), .mp_count(mp_count), .jmp_count(jmp_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit en     = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%h, expected 0x%h", nm, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: what instruction sits in ID, what fetch predicted for it,
  // and the outcome table applied to that.
  // ---------------------------------------------------------------------------
  int unsigned m_pc, m_tgt;
  bit m_found, m_taken, m_valid;
  int unsigned m_br, m_mp, m_jmp;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  typedef struct {
    int unsigned pc_src, we, tgt, jmp, pcs2;
    bit flush, mp;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    int   off;
    bit   act;
    off    = $signed(id_imm) * 4;
    e.tgt  = m_pc + 4 + off;
    e.jmp  = ((m_pc + 4) & 32'hF000_0000) | (int'(id_jmp_index) * 4);
    e.pcs2 = m_pc;
    e.pc_src = 0; e.we = 0; e.flush = 0; e.mp = 0;
    act = (id_rs_data == id_rt_data) != id_branch_ne;
    if (!m_valid) begin
      // bubble: no action
    end else if (id_is_jump) begin
      e.pc_src = 2; e.flush = 1;
    end else if (id_is_branch) begin
      if (!m_found) begin
        if (act) begin e.we = 1; e.pc_src = 1; e.flush = 1; e.mp = 1; end
      end else if (m_taken) begin
        if (!act)               begin e.we = 4; e.flush = 1; e.mp = 1; end
        else if (m_tgt != e.tgt) begin e.we = 3; e.pc_src = 1; e.flush = 1; e.mp = 1; end
      end else if (act) begin
        e.we = 2; e.pc_src = 1; e.flush = 1; e.mp = 1;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      m_pc = 0; m_tgt = 0; m_found = 0; m_taken = 0; m_valid = 0;
      m_br = 0; m_mp = 0; m_jmp = 0;
    end else if (pc_write) begin
      e = model_out();
      if (m_valid && id_is_branch && !id_is_jump && m_br < CMAX) m_br++;
      if (e.mp && m_mp < CMAX) m_mp++;
      if (m_valid && id_is_jump && m_jmp < CMAX) m_jmp++;
      m_pc = if_pc; m_tgt = if_pred_target;
      m_found = if_find_in_btb; m_taken = if_btb_taken;
      m_valid = !e.flush;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (en) begin
      e = model_out();
      chk("m_pc_src", 32'(pc_src), e.pc_src);
      chk("m_write_entry", 32'(write_entry), e.we);
      chk("m_br_target", pc_plus4_plus_off, e.tgt);
      chk("m_jmp_addr", jmp_addr, e.jmp);
      chk("m_pc_stage2", pc_stage2, e.pcs2);
      chk("m_flush", 32'(flush), 32'(e.flush));
      chk("m_mispredict", 32'(mispredict), 32'(e.mp));
`ifdef BRU_PERF_CNT_EN
      chk("m_br_count", 32'(br_count), m_br);
      chk("m_mp_count", 32'(mp_count), m_mp);
      chk("m_jmp_count", 32'(jmp_count), m_jmp);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic drive_if(input logic [31:0] pc, input logic f, input logic t,
                          input logic [31:0] tgt);
    if_pc = pc; if_find_in_btb = f; if_btb_taken = t; if_pred_target = tgt;
  endtask

  task automatic drive_id(input logic b, input logic ne, input logic j,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] imm, input logic [25:0] idx);
    id_is_branch = b; id_branch_ne = ne; id_is_jump = j;
    id_rs_data = rs; id_rt_data = rt; id_imm = imm; id_jmp_index = idx;
  endtask

  task automatic nop();
    drive_id(0, 0, 0, 0, 0, 16'h0, 26'h0);
  endtask

  task automatic chk_ctl(input string nm, input logic [1:0] ps, input logic [2:0] we,
                         input logic fl, input logic mp);
    chk({nm, "_pc_src"}, 32'(pc_src), 32'(ps));
    chk({nm, "_we"}, 32'(write_entry), 32'(we));
    chk({nm, "_flush"}, 32'(flush), 32'(fl));
    chk({nm, "_mp"}, 32'(mispredict), 32'(mp));
  endtask

  initial begin
    reset = 1'b1; pc_write = 1'b1;
    drive_if(0, 0, 0, 0); nop();
    nxt();
    en = 1'b1;
    nxt();
    reset = 1'b0;

    // Reset state, then a nop at 0x40.
    drive_if(32'h40, 0, 0, 0);
    @(negedge clk);
    chk_ctl("rst", 2'b00, 3'b000, 0, 0);
    chk("rst_pc_stage2", pc_stage2, 32'h0);
    nxt();
    drive_if(32'h100, 0, 0, 0);
    @(negedge clk);
    chk_ctl("nop", 2'b00, 3'b000, 0, 0);
    chk("nop_pc_stage2", pc_stage2, 32'h40);

    // beq, BTB miss, taken: allocate and redirect; the next ID slot is a bubble.
    nxt();
    drive_id(1, 0, 0, 5, 5, 16'h0003, 0);
    drive_if(32'h104, 0, 0, 0);
    @(negedge clk);
    chk("alloc_tgt", pc_plus4_plus_off, 32'h110);
    chk_ctl("alloc", 2'b01, 3'b001, 1, 1);
    nxt();
    drive_if(32'h200, 1, 1, 32'h180);
    @(negedge clk);
    chk_ctl("bubble", 2'b00, 3'b000, 0, 0);
    chk("bubble_pc_stage2", pc_stage2, 32'h104);

    // bne predicted taken but operands equal: train not-taken.
    nxt();
    drive_id(1, 1, 0, 7, 7, 16'h0010, 0);
    drive_if(32'h204, 0, 0, 0);
    @(negedge clk);
    chk_ctl("train_nt", 2'b00, 3'b100, 1, 1);
    nxt();
    nop();
    drive_if(32'h300, 1, 1, 32'h2F0);

    // beq backwards, predicted target correct; then same branch with stale target.
    nxt();
    drive_id(1, 0, 0, 9, 9, 16'hFFFB, 0);
    drive_if(32'h300, 1, 1, 32'h2E0);
    @(negedge clk);
    chk("hit_tgt", pc_plus4_plus_off, 32'h2F0);
    chk_ctl("hit_ok", 2'b00, 3'b000, 0, 0);
    nxt();
    drive_if(32'h304, 0, 0, 0);
    @(negedge clk);
    chk_ctl("fix_tgt", 2'b01, 3'b011, 1, 1);
    nxt();
    nop();
    drive_if(32'h1000_0040, 0, 0, 0);

    // Jump, then a 3-cycle stall during which outputs hold.
    nxt();
    drive_id(0, 0, 1, 1, 2, 16'h0, 26'h0000100);
    drive_if(32'h1000_0044, 0, 0, 0);
    @(negedge clk);
    chk("jmp_addr", jmp_addr, 32'h1000_0400);
    chk_ctl("jump", 2'b10, 3'b000, 1, 0);
    pc_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      id_rs_data = $urandom; id_rt_data = $urandom;
      drive_if(32'hDEAD_0000, 1, 1, 32'h0);
      @(negedge clk);
      chk("stall_jmp_addr", jmp_addr, 32'h1000_0400);
      chk("stall_pc_stage2", pc_stage2, 32'h1000_0040);
      chk_ctl("stall", 2'b10, 3'b000, 1, 0);
    end
`ifdef BRU_PERF_CNT_EN
    chk("stall_jmp_count", 32'(jmp_count), 32'd0);
`endif
    pc_write = 1'b1;
    nxt();
    nop();
    drive_if(32'h500, 1, 0, 0);
    @(negedge clk);
    chk_ctl("post_stall", 2'b00, 3'b000, 0, 0);
    chk("post_stall_pc", pc_stage2, 32'hDEAD_0000);

    // Predicted not-taken but taken: train taken.
    nxt();
    drive_id(1, 0, 0, 1, 1, 16'h0010, 0);
    drive_if(32'h504, 0, 0, 0);
    @(negedge clk);
    chk_ctl("train_t", 2'b01, 3'b010, 1, 1);
    nxt();
    nop();
    drive_if(32'h600, 1, 0, 0);

    // Predicted not-taken and not taken; then BTB miss not taken.
    nxt();
    drive_id(1, 0, 0, 1, 2, 16'h0010, 0);
    drive_if(32'h604, 0, 0, 0);
    @(negedge clk);
    chk_ctl("nt_ok", 2'b00, 3'b000, 0, 0);
    nxt();
    drive_id(1, 1, 0, 3, 3, 16'h0020, 0);
    drive_if(32'h608, 0, 0, 0);
    @(negedge clk);
    chk_ctl("miss_nt", 2'b00, 3'b000, 0, 0);

    // Branch and jump decoded together: handled as a jump.
    nxt();
    drive_id(1, 0, 1, 4, 4, 16'h0001, 26'h3);
    drive_if(32'h700, 0, 0, 0);
    @(negedge clk);
    chk_ctl("collide", 2'b10, 3'b000, 1, 0);
    chk("collide_jmp", jmp_addr, 32'h0000_000C);
    nxt();
    nop();
    nxt();

    // Mispredict in ID with reset asserted across the edge.
    drive_id(1, 1, 0, 1, 2, 16'h0004, 0);
    drive_if(32'h704, 0, 0, 0);
    @(negedge clk);
    chk_ctl("pre_rst", 2'b01, 3'b001, 1, 1);
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    @(negedge clk);
    chk_ctl("mid_rst", 2'b00, 3'b000, 0, 0);
    chk("mid_rst_pc", pc_stage2, 32'h0);

`ifdef BRU_PERF_CNT_EN
    chk("cnt_rst_br", 32'(br_count), 32'd0);
    chk("cnt_rst_mp", 32'(mp_count), 32'd0);
    nop();
    for (int i = 0; i < 17; i++) begin
      drive_if(32'h800 + 32'(i) * 8, 0, 0, 0);
      nxt();
      drive_id(1, 1, 0, 1, 2, 16'h0002, 0);
      drive_if(32'h804 + 32'(i) * 8, 0, 0, 0);
      @(negedge clk);
      nxt();
      nop();
    end
    @(negedge clk);
    chk("sat_mp_count", 32'(mp_count), 32'hF);
    chk("sat_br_count", 32'(br_count), 32'hF);
`endif

    nxt();
    en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
